dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 139 +++++++++++++
 tb/tb_dmem_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller: byte/half/word loads and stores with
// configurable wait states, little-endian lanes and alignment/range faults.
module dmem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 1024,
    parameter int WAIT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              DMEM_req,
    input  logic              DMEM_we,
    input  logic [1:0]        DMEM_size,
    input  logic              DMEM_unsigned,
    input  logic [ADDR_W-1:0] DMEM_address,
    input  logic [31:0]       DMEM_data_in,
    output logic              DMEM_ready,
    output logic              DMEM_valid,
    output logic [31:0]       DMEM_data_out,
    output logic              DMEM_error
);

    localparam int                IDX_W     = $clog2(DEPTH);
    localparam logic [63:0]       LOW_MASK  = (64'd1 << (IDX_W + 2)) - 64'd1;
    localparam logic [ADDR_W-1:0] HI_MASK   = ~LOW_MASK[ADDR_W-1:0];
    localparam logic [3:0]        WAIT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT_ST, ACCESS, DONE} state_t;

    state_t            state;
    logic [3:0]        wait_cnt;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [31:0]       mem [DEPTH];

    logic [IDX_W-1:0]  word_idx;
    logic [31:0]       rd_shift;
    logic [31:0]       load_data;
    logic [31:0]       lane_data;
    logic [3:0]        lane_en;
    logic              fault;

    assign DMEM_ready = (state == IDLE);
    assign word_idx   = addr_q[IDX_W+1:2];
    assign rd_shift   = mem[word_idx] >> {addr_q[1:0], 3'b000};

    // Decode the latched request into byte lanes, load extension and fault.
    always_comb begin
        fault     = 1'b0;
        lane_en   = 4'b0000;
        lane_data = wdata_q;
        load_data = rd_shift;
        case (size_q)
            2'b00: begin
                lane_en   = 4'b0001 << addr_q[1:0];
                lane_data = {4{wdata_q[7:0]}};
                load_data = {{24{~uns_q & rd_shift[7]}}, rd_shift[7:0]};
            end
            2'b01: begin
                fault     = addr_q[0];
                lane_en   = 4'b0011 << addr_q[1:0];
                lane_data = {2{wdata_q[15:0]}};
                load_data = {{16{~uns_q & rd_shift[15]}}, rd_shift[15:0]};
            end
            2'b10: begin
                fault     = |addr_q[1:0];
                lane_en   = 4'b1111;
                lane_data = wdata_q;
                load_data = rd_shift;
            end
            default: fault = 1'b1;
        endcase
        if (|(addr_q & HI_MASK)) fault = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wait_cnt      <= 4'd0;
            DMEM_valid    <= 1'b0;
            DMEM_error    <= 1'b0;
            DMEM_data_out <= 32'd0;
            we_q          <= 1'b0;
            size_q        <= 2'b00;
            uns_q         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (DMEM_req) begin
                        we_q    <= DMEM_we;
                        size_q  <= DMEM_size;
                        uns_q   <= DMEM_unsigned;
                        addr_q  <= DMEM_address;
                        wdata_q <= DMEM_data_in;
                        if (WAIT > 0) begin
                            state    <= WAIT_ST;
                            wait_cnt <= WAIT_INIT;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                WAIT_ST: begin
                    if (wait_cnt == 4'd0) state <= ACCESS;
                    else wait_cnt <= wait_cnt - 4'd1;
                end
                ACCESS: begin
                    state         <= DONE;
                    DMEM_valid    <= 1'b1;
                    DMEM_error    <= fault;
                    DMEM_data_out <= (fault || we_q) ? 32'd0 : load_data;
                end
                DONE: begin
                    state         <= IDLE;
                    DMEM_valid    <= 1'b0;
                    DMEM_error    <= 1'b0;
                    DMEM_data_out <= 32'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // No reset here: memory contents survive reset, and an abandoned access
    // never reaches ACCESS because reset already forced the FSM to IDLE.
    always_ff @(posedge clk) begin
        if (state == ACCESS && we_q && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) mem[word_idx][b*8 +: 8] <= lane_data[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed scoreboard bench for dmem_ctrl: a WAIT=1 instance (unit 0) and a
// WAIT=0 instance (unit 1) exercised through lane, fault and reset scenarios.
module tb_dmem_ctrl;

    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b10;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req, we, uns, ready, valid, err;
    logic [1:0][1:0]  size;
    logic [1:0][31:0] addr, din, dout;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(32), .DEPTH(1024), .WAIT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .DMEM_req(req[0]), .DMEM_we(we[0]), .DMEM_size(size[0]),
        .DMEM_unsigned(uns[0]), .DMEM_address(addr[0]), .DMEM_data_in(din[0]),
        .DMEM_ready(ready[0]), .DMEM_valid(valid[0]),
        .DMEM_data_out(dout[0]), .DMEM_error(err[0])
    );

    dmem_ctrl #(.ADDR_W(32), .DEPTH(1024), .WAIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .DMEM_req(req[1]), .DMEM_we(we[1]), .DMEM_size(size[1]),
        .DMEM_unsigned(uns[1]), .DMEM_address(addr[1]), .DMEM_data_in(din[1]),
        .DMEM_ready(ready[1]), .DMEM_valid(valid[1]),
        .DMEM_data_out(dout[1]), .DMEM_error(err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleOutputs(input int u, input string tag);
        check($sformatf("%s_valid_u%0d", tag, u), 32'(valid[u]), 32'd0);
        check($sformatf("%s_error_u%0d", tag, u), 32'(err[u]), 32'd0);
        check($sformatf("%s_data_u%0d", tag, u), dout[u], 32'd0);
        check($sformatf("%s_ready_u%0d", tag, u), 32'(ready[u]), 32'd1);
    endtask

    // Present one request, push its expected result, scramble inputs after accept.
    task automatic applyStimulus(input int u, input logic w, input logic [1:0] sz,
                                 input logic un, input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] exp_data, input logic exp_err);
        @(negedge clk);
        check($sformatf("ready_pre_accept_u%0d", u), 32'(ready[u]), 32'd1);
        req[u]  = 1'b1;
        we[u]   = w;
        size[u] = sz;
        uns[u]  = un;
        addr[u] = a;
        din[u]  = d;
        sb.push_back(exp_t'{exp_data, exp_err});
        @(posedge clk);
        #1;
        req[u]  = 1'b0;
        we[u]   = 1'($urandom);
        size[u] = 2'($urandom);
        uns[u]  = 1'($urandom);
        addr[u] = $urandom;
        din[u]  = $urandom;
        check($sformatf("ready_post_accept_u%0d", u), 32'(ready[u]), 32'd0);
    endtask

    // Wait (bounded) for the completion pulse and compare against the scoreboard.
    task automatic checkOutput(input int u, input string tag);
        int   lat;
        exp_t e;
        lat = 0;
        while (valid[u] !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = (sb.size() > 0) ? sb.pop_front() : exp_t'{32'hDEAD_0000, 1'b1};
        check($sformatf("%s_latency", tag), 32'(lat), (u == 0) ? 32'd2 : 32'd1);
        check($sformatf("%s_data", tag), dout[u], e.data);
        check($sformatf("%s_error", tag), 32'(err[u]), 32'(e.err));
        @(posedge clk);
        #1;
        check($sformatf("%s_pulse_end", tag), {30'd0, err[u], valid[u]}, 32'd0);
        check($sformatf("%s_data_cleared", tag), dout[u], 32'd0);
    endtask

    task automatic access(input int u, input logic w, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_data, input logic exp_err, input string tag);
        applyStimulus(u, w, sz, un, a, d, exp_data, exp_err);
        checkOutput(u, tag);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses;
        rst_n = 1'b1;
        req = '0; we = '0; uns = '0; size = '0; addr = '0; din = '0;
        #1 rst_n = 1'b0;
        #2;
        checkIdleOutputs(0, "reset");
        checkIdleOutputs(1, "reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        $display("[TB] word store/load");
        access(0, 1, SW, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, "st_w_10");
        access(0, 0, SW, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, "ld_w_10");

        $display("[TB] byte lanes");
        access(0, 1, SB, 0, 32'h13, 32'h12345680, 32'h0, 0, "st_b_13");
        access(0, 0, SB, 0, 32'h13, 32'h0, 32'hFFFFFF80, 0, "ld_sb_13");
        access(0, 0, SB, 1, 32'h13, 32'h0, 32'h00000080, 0, "ld_ub_13");
        access(0, 0, SW, 0, 32'h10, 32'h0, 32'h80ADBEEF, 0, "ld_w_10_b");

        $display("[TB] half lanes and faults");
        access(0, 1, SH, 0, 32'h12, 32'hABCD8001, 32'h0, 0, "st_h_12");
        access(0, 0, SH, 0, 32'h12, 32'h0, 32'hFFFF8001, 0, "ld_sh_12");
        access(0, 0, SH, 1, 32'h12, 32'h0, 32'h00008001, 0, "ld_uh_12");
        access(0, 0, SW, 0, 32'h11, 32'h0, 32'h0, 1, "ld_w_11_fault");
        access(0, 1, SH, 0, 32'h11, 32'h0000FFFF, 32'h0, 1, "st_h_11_fault");
        access(0, 1, 2'b11, 0, 32'h10, 32'hFFFFFFFF, 32'h0, 1, "st_rsvd_fault");
        access(0, 1, SW, 0, 32'h12, 32'h0, 32'h0, 1, "st_w_12_fault");
        access(0, 0, SW, 0, 32'h10, 32'h0, 32'h8001BEEF, 0, "ld_w_10_c");
        access(0, 0, SB, 0, 32'h10, 32'h0, 32'hFFFFFFEF, 0, "ld_sb_10");
        access(0, 0, SH, 0, 32'h10, 32'h0, 32'hFFFFBEEF, 0, "ld_sh_10");

        $display("[TB] out-of-range addresses");
        access(0, 1, SW, 0, 32'h0, 32'hCAFEF00D, 32'h0, 0, "st_w_0");
        access(0, 1, SW, 0, 32'h1000, 32'h11111111, 32'h0, 1, "st_w_1000_fault");
        access(0, 0, SW, 0, 32'h80000000, 32'h0, 32'h0, 1, "ld_w_hi_fault");
        access(0, 0, SW, 0, 32'h0, 32'h0, 32'hCAFEF00D, 0, "ld_w_0");

        $display("[TB] reset during wait state");
        access(0, 1, SW, 0, 32'h20, 32'hA5A5A5A5, 32'h0, 0, "st_w_20");
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; size[0] = SW; uns[0] = 1'b0;
        addr[0] = 32'h20; din[0] = 32'h12345678;
        @(posedge clk);
        #1;
        req[0] = 1'b0;
        check("abort_in_wait_ready", 32'(ready[0]), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        checkIdleOutputs(0, "async_reset");
        @(negedge clk) rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (valid[0] === 1'b1) pulses++;
        end
        check("abort_no_valid", 32'(pulses), 32'd0);
        access(0, 0, SW, 0, 32'h20, 32'h0, 32'hA5A5A5A5, 0, "ld_w_20_old");

        $display("[TB] zero wait states, request held high");
        for (int k = 0; k < 9; k++)
            access(1, 1, SW, 0, 32'h40 + 32'(4 * k), 32'hB000 + 32'(k), 32'h0, 0,
                   $sformatf("prefill_%0d", k));
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            req[1] = 1'b1; we[1] = 1'b1; size[1] = SW; uns[1] = 1'b0;
            addr[1] = 32'h40 + 32'(4 * k);
            din[1]  = 32'h100 + 32'(k);
            @(posedge clk);
            #1;
            check($sformatf("held_valid_%0d", k), 32'(valid[1]), (k % 3 == 1) ? 32'd1 : 32'd0);
            check($sformatf("held_ready_%0d", k), 32'(ready[1]), (k % 3 == 2) ? 32'd1 : 32'd0);
            check($sformatf("held_data_%0d", k), dout[1], 32'd0);
        end
        @(negedge clk);
        req[1] = 1'b0;
        for (int k = 0; k < 9; k++)
            access(1, 0, SW, 0, 32'h40 + 32'(4 * k), 32'h0,
                   (k % 3 == 0) ? 32'h100 + 32'(k) : 32'hB000 + 32'(k), 0,
                   $sformatf("held_readback_%0d", k));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
